// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit signed multiply/divide unit with register-file write-back
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      dest_reg,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [4:0]      wr_reg,
  output logic [XLEN-1:0] wr_data
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        dest_q, dest_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_reg_q, wr_reg_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;

  logic              a_neg, b_neg, accept, b_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_sub;
  logic              div_ok;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;

  assign a_neg   = src_a[XLEN-1];
  assign b_neg   = src_b[XLEN-1];
  assign a_mag   = a_neg ? -src_a : src_a;
  assign b_mag   = b_neg ? -src_b : src_b;
  assign b_zero  = (src_b == '0);
  assign div_ovf = (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
  // busy_q also covers the completion cycle, so a start there is dropped
  assign accept  = start && !busy_q && !flush;

  // Multiply: {acc, lo} is the 64-bit product shifting right, lo starts as |a|
  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  // Divide: acc is the partial remainder, lo shifts the dividend out and quotient in
  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_ok    = (div_shift >= {1'b0, b_q});
  assign div_sub   = div_shift[XLEN-1:0] - b_q;

  assign prod   = {acc_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_q : lo_q;
  assign rem_s  = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dest_d    = dest_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    b_d       = b_q;
    res_d     = res_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;

    if (done_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = op;
          dest_d = dest_reg;
          cnt_d  = '0;
          busy_d = 1'b1;
          b_d    = b_mag;
          neg_d  = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
          acc_d  = '0;
          lo_d   = a_mag;
          if (op[1] && b_zero) begin
            res_d   = (op == OP_REM) ? src_a : '1;
            state_d = S_DONE;
          end else if (op[1] && div_ovf) begin
            res_d   = (op == OP_REM) ? '0 : src_a;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (op_q[1]) begin
            acc_d = div_ok ? div_sub : div_shift[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], div_ok};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          case (op_q)
            OP_MUL:  res_d = prod_s[XLEN-1:0];
            OP_MULH: res_d = prod_s[2*XLEN-1:XLEN];
            OP_DIV:  res_d = quo_s;
            default: res_d = rem_s;
          endcase
          state_d = S_DONE;
        end
      end

      default: begin
        done_d    = 1'b1;
        wr_en_d   = (dest_q != 5'd0);
        wr_reg_d  = dest_q;
        wr_data_d = res_q;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit (vector table + scoreboard)
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  dest_reg = '0;
  logic        flush = 1'b0;
  logic        busy, done, wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dest_reg(dest_reg), .flush(flush), .busy(busy), .done(done), .wr_en(wr_en),
    .wr_reg(wr_reg), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    logic        wren;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Advance to the next falling edge and score any write-back seen there.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (wr_en) wr_count++;
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=reg%0d/%h required=no_done", wr_reg, wr_data);
      end else begin
        e = sbq.pop_front();
        check("wr_data", wr_data, e.data);
        check("wr_reg", {27'd0, wr_reg}, {27'd0, e.dest});
        check("wr_en", {31'd0, wr_en}, {31'd0, e.wren});
        check("latency", 32'(cyc), 32'(e.due));
      end
    end else if (wr_en) begin
      checks++;
      failures++;
      $display("FAIL wr_en_without_done actual=1 required=0");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] expv, input bit special);
    exp_t e;
    op = o; src_a = a; src_b = b; dest_reg = d; start = 1'b1;
    e.dest = d; e.data = expv; e.wren = (d != 5'd0); e.due = cyc + (special ? 2 : 35);
    sbq.push_back(e);
    cycle();
    start = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending%0d required=0", sbq.size());
      sbq.delete();
    end
    cycle();
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    case (o)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
      2'b10: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
    endcase
  endfunction

  vec_t vt[15];

  initial begin
    int w0;
    int n;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vt[0]  = '{2'b00, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
    vt[1]  = '{2'b01, 32'h8000_0000,  32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0};
    vt[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 1'b0};
    vt[3]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0};
    vt[4]  = '{2'b11, 32'd7,          32'hFFFF_FFFE, 5'd9,  32'd1,         1'b0};
    vt[5]  = '{2'b10, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1'b1};
    vt[6]  = '{2'b11, 32'd5,          32'd0,         5'd11, 32'd5,         1'b1};
    vt[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1};
    vt[8]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,         1'b1};
    vt[9]  = '{2'b01, 32'h8000_0000,  32'h8000_0000, 5'd14, 32'h4000_0000, 1'b0};
    vt[10] = '{2'b00, 32'h8000_0000,  32'h8000_0000, 5'd15, 32'd0,         1'b0};
    vt[11] = '{2'b10, 32'd7,          32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, 1'b0};
    vt[12] = '{2'b00, 32'd3,          32'd4,         5'd0,  32'd12,        1'b0};
    vt[13] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd31, 32'd0,         1'b0};
    vt[14] = '{2'b10, 32'd100,        32'd7,         5'd1,  32'd14,        1'b0};

    // Reset held with a start pulse: nothing may happen
    start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9; dest_reg = 5'd3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
    end
    start = 1'b0;
    rst = 1'b1;
    cycle();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].dest, vt[i].exp, vt[i].special);
      wait_idle();
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      issue(ro, ra, rb, 5'(i + 2), ref_op(ro, ra, rb), ro[1] && (rb == 32'd0));
      wait_idle();
    end

    // Start while busy and start in the completion cycle are both dropped
    w0 = wr_count;
    issue(2'b00, 32'd6, 32'd9, 5'd7, 32'd54, 1'b0);
    repeat (3) cycle();
    op = 2'b10; src_a = 32'd50; src_b = 32'd5; dest_reg = 5'd8; start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    check("first_write_seen", 32'(sbq.size()), 32'd0);
    op = 2'b00; src_a = 32'd2; src_b = 32'd2; dest_reg = 5'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    check("start_in_done_dropped", {31'd0, busy}, 32'd0);
    repeat (40) cycle();
    check("single_write", 32'(wr_count - w0), 32'd1);

    // Flush in CALC at count 10, then an immediate new operation
    op = 2'b10; src_a = 32'd100; src_b = 32'd7; dest_reg = 5'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    issue(2'b00, 32'd6, 32'd7, 5'd3, 32'd42, 1'b0);
    wait_idle();

    // Flush together with start in IDLE drops the start
    op = 2'b00; src_a = 32'd1; src_b = 32'd1; dest_reg = 5'd4; start = 1'b1; flush = 1'b1;
    cycle();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) cycle();

    // Flush arriving in the internal DONE state must not cancel the write
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 5'd20, 32'hFFFF_FFFF, 1'b0);
    repeat (33) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    wait_idle();

    // Reset during FIX: immediate idle, no write, outputs cleared
    w0 = wr_count;
    op = 2'b00; src_a = 32'd3; src_b = 32'd5; dest_reg = 5'd4; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (32) cycle();
    rst = 1'b0;
    #1;
    check("fix_rst_busy", {31'd0, busy}, 32'd0);
    check("fix_rst_done", {31'd0, done}, 32'd0);
    check("fix_rst_wr_data", wr_data, 32'd0);
    repeat (2) cycle();
    rst = 1'b1;
    repeat (40) cycle();
    check("fix_rst_no_write", 32'(wr_count - w0), 32'd0);
    check("fix_rst_busy_after", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
